// File: rtl/seg7_hex_scanner_if.sv
// rtl/seg7_hex_scanner_if.sv - display value inputs and seven-segment pad outputs
`timescale 1ns/1ps
interface seg7_hex_scanner_if;
  logic [15:0] value;
  logic        lz_blank;
  logic [3:0]  dp_mask;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (output value, output lz_blank, output dp_mask,
                  input an, input seg, input dp);
  modport slave  (input value, input lz_blank, input dp_mask,
                  output an, output seg, output dp);
endinterface

// File: rtl/seg7_hex_scanner.sv
// rtl/seg7_hex_scanner.sv - four-digit hex scanner with blanking, zero suppression and frame-coherent capture
`timescale 1ns/1ps
module seg7_hex_scanner #(
  parameter int DIGIT_TICKS = 100000,
  parameter int BLANK_TICKS = 2000
) (
  input  logic                clk,
  input  logic                reset,
  seg7_hex_scanner_if.slave   bus
);
  localparam int            TW        = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_TICKS - 1);

  logic [TW-1:0] tick_q, tick_d;
  logic [1:0]    digit_q, digit_d;
  logic [15:0]   sh_value_q;
  logic          sh_lz_q;
  logic [3:0]    sh_dp_q;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;

  logic          wrap, frame_end, blank, suppress;
  logic [3:0]    nib;
  logic [3:0]    upper_zero;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    wrap      = (tick_q == TICK_LAST);
    frame_end = wrap && (digit_q == 2'd3);
    tick_d    = wrap ? '0 : tick_q + TW'(1);
    digit_d   = wrap ? digit_q + 2'd1 : digit_q;

    nib = sh_value_q[{digit_q, 2'b00} +: 4];

    // upper_zero[k]: nibbles k..3 all zero; digit 0 is never a leading zero
    upper_zero[3] = (sh_value_q[15:12] == 4'h0);
    upper_zero[2] = upper_zero[3] && (sh_value_q[11:8] == 4'h0);
    upper_zero[1] = upper_zero[2] && (sh_value_q[7:4] == 4'h0);
    upper_zero[0] = 1'b0;
    suppress      = sh_lz_q && upper_zero[digit_q];

    blank = (32'(tick_q) < 32'(BLANK_TICKS));

    if (blank || suppress) begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~(8'b1 << digit_q);
      seg_d = hex7(nib);
      dp_d  = ~sh_dp_q[digit_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q     <= '0;
      digit_q    <= 2'd0;
      sh_value_q <= 16'h0000;
      sh_lz_q    <= 1'b0;
      sh_dp_q    <= 4'h0;
      an_q       <= 8'hFF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      tick_q  <= tick_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      // shadows only move on the last cycle of digit 3 so a frame is never torn
      if (frame_end) begin
        sh_value_q <= bus.value;
        sh_lz_q    <= bus.lz_blank;
        sh_dp_q    <= bus.dp_mask;
      end
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
endmodule

// File: doc/seg7_hex_scanner.md
# seg7_hex_scanner

Time-multiplexed seven-segment driver that shows a 16-bit value as four hexadecimal digits on the Nexys4 DDR display. It sits directly downstream of the free-running overflow counter and consumes that counter's 16-bit `led` word, alongside or in place of the LEDs. Digit selection, segment decoding, anti-ghost blanking, leading-zero suppression and per-digit decimal points are handled here. The displayed value is captured once per scan frame so a digit never changes partway through a frame.

## Interface
- `DIGIT_TICKS`, default 100000: clock cycles per digit slot (1 ms at 100 MHz). Legal range is 4 or more.
- `BLANK_TICKS`, default 2000: cycles at the start of each slot with all anodes off (anti-ghost). Legal range is 0 to `DIGIT_TICKS`-1.
- `clk`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `value`  in  16  word to display; digit0 = `value[3:0]` (rightmost) … digit3 = `value[15:12]`.
- `lz_blank`  in  1  1 = suppress leading zero digits.
- `dp_mask`  in  4  active-high decimal point enable per digit; bit i = digit i.
- `an`  out  8  anodes, active-low. `an[7:4]` is always 1.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-low.
- `dp`  out  1  decimal point, active-low.

## Operation
- State: `tick` counter (width clog2(`DIGIT_TICKS`)), `digit` index (2 bits), shadow registers `sh_value[15:0]`, `sh_lz`, `sh_dp[3:0]`.
- `tick` counts 0…`DIGIT_TICKS`-1 and wraps to 0. At the wrap, `digit` advances 0→1→2→3→0.
- Frame boundary: the cycle with `tick`=`DIGIT_TICKS`-1 and `digit`=3. On that edge the shadows load `value`, `lz_blank` and `dp_mask`. No other cycle updates the shadows, and input changes mid-frame are ignored.
- Slot output rules:
  - If `tick` < `BLANK_TICKS`, or the digit is suppressed: `an`=8'hFF, `seg`=7'h7F, `dp`=1.
  - Otherwise: `an`=~(8'b1 << `digit`), `seg`=hex(`sh_value` nibble), `dp`=~`sh_dp[digit]`.
- Leading-zero suppression, when `sh_lz`=1:
  - Digit k (k = 3, 2, 1) is suppressed when nibbles k through 3 are all 0.
  - Digit 0 is never suppressed.
  - Interior zeros are shown.
- Hex table, active-low `{g..a}`:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Outputs `an`, `seg` and `dp` are registered (glitch-free pads).

## Timing
- Reset values:
  - Outputs: `an`=8'hFF, `seg`=7'h7F, `dp`=1.
  - State: `tick`=0, `digit`=0, `sh_value`=0, `sh_lz`=0, `sh_dp`=0.
- The first frame after reset therefore displays "0000" with no decimal points.
- Outputs lag internal state by exactly one cycle.
- Counting cycles from the first edge with `reset` sampled low as cycle 1:
  - Digit 0's anode is low during cycles `BLANK_TICKS`+1 … `DIGIT_TICKS`.
  - Each later slot is offset by `DIGIT_TICKS`.
  - Frame period is 4·`DIGIT_TICKS`.
- Capture-to-display latency: a value captured at a boundary first appears on the pads `BLANK_TICKS`+1 cycles after that boundary edge.
- Reset mid-operation: outputs return to reset values on the next edge, the scan restarts at digit 0 and the shadows clear. Reset has priority over the boundary load.
- With `BLANK_TICKS`=0, anodes never go fully dark between slots. Exactly one of `an[3:0]` is low in every cycle, except the first post-reset cycle and suppressed slots.
- At most one `an` bit is low in any cycle.

## Test plan
All scenarios use `DIGIT_TICKS`=8 and `BLANK_TICKS`=2.
- Reset and first frame: hold reset 3 cycles → `an`=FF, `seg`=7F, `dp`=1. After release, `an`=FE and `seg`=1000000 during cycles 3–8; then `an`=FD for cycles 11–16, FB for 19–24, F7 for 27–32; FF in the gaps.
- Full decode: `value`=16'h1A8F before a boundary → next frame shows `an`=FE with F(0001110), then FD with 8(0000000), FB with A(0001000), F7 with 1(1111001). Sweep all 16 nibble values through digit 0 and match the table.
- Frame coherency: change `value` from 16'h1234 to 16'hABCD while digit 1 is active → remaining digits of that frame still show 3, 2, 1; ABCD appears only from the next frame.
- Leading-zero suppression with `lz_blank`=1:
  - `value`=0005 → slots 1–3 keep `an`=FF; digit 0 shows 0010010.
  - `value`=0000 → a single 0 is shown.
  - `value`=0100 → digits 2, 1 and 0 are shown.
- Decimal point: `dp_mask`=4'b0100 → `dp`=0 only while `an`=FB; 1 elsewhere, including during blanking.
- Reset mid-frame: assert reset while digit 2 is active → next cycle `an`=FF and the shadows clear; after release, the scan restarts at digit 0 showing 0. `an[7:4]` stays 1 throughout every scenario.
